// File: rtl/riscv_pkg.sv
// riscv_pkg: load/store size encodings and LSU state type
package riscv_pkg;
    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;
    typedef enum logic {LSU_IDLE, LSU_BUSY} lsu_state_t;
endpackage

// File: rtl/lsu_rd_extend.sv
// lsu_rd_extend: picks the addressed byte/half of a read word and sign/zero-extends it
module lsu_rd_extend
    import riscv_pkg::*;
(
    input  logic [2:0]  size_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] word_i,
    output logic [31:0] rd_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    always_comb begin
        byte_sel = word_i[{offset_i, 3'b000} +: 8];
        half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
        rd_o = size_i == LDST_B  ? {{24{byte_sel[7]}}, byte_sel} :
               size_i == LDST_BU ? {24'b0, byte_sel} :
               size_i == LDST_H  ? {{16{half_sel[15]}}, half_sel} :
               size_i == LDST_HU ? {16'b0, half_sel} : word_i;
    end
endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu: core-to-data_mem load/store unit with alignment checks and response timeout
module riscv_lsu
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        lsu_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);
    localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO = CW'(TIMEOUT_CYCLES);

    lsu_state_t state_q, state_d;
    logic [2:0]    size_q, size_d;
    logic [1:0]    off_q, off_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          legal, is_half;
    logic [3:0]    be;
    logic [31:0]   ext_rd;

    lsu_rd_extend u_ext (
        .size_i  (size_q),
        .offset_i(off_q),
        .word_i  (mem_rd_i),
        .rd_o    (ext_rd)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= LSU_IDLE;
            size_q  <= '0;
            off_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        is_half = core_size_i == LDST_H || core_size_i == LDST_HU;
        legal = core_size_i == LDST_B || core_size_i == LDST_BU ||
                (is_half && !core_addr_i[0]) ||
                (core_size_i == LDST_W && core_addr_i[1:0] == 2'b00);
        be = core_size_i == LDST_W ? 4'b1111 :
             is_half ? 4'b0011 << {core_addr_i[1], 1'b0} : 4'b0001 << core_addr_i[1:0];
        state_d      = state_q;
        size_d       = size_q;
        off_d        = off_q;
        cnt_d        = cnt_q;
        core_rd_o    = '0;
        core_stall_o = 1'b0;
        lsu_err_o    = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_be_o     = '0;
        mem_addr_o   = '0;
        mem_wd_o     = '0;
        if (state_q == LSU_IDLE) begin
            if (core_req_i && legal) begin
                mem_req_o    = 1'b1;
                mem_we_o     = core_we_i;
                mem_be_o     = be;
                mem_addr_o   = {core_addr_i[31:2], 2'b00};
                mem_wd_o     = core_size_i == LDST_W ? core_wd_i :
                               is_half ? {2{core_wd_i[15:0]}} : {4{core_wd_i[7:0]}};
                core_stall_o = 1'b1;
                size_d       = core_size_i;
                off_d        = core_addr_i[1:0];
                cnt_d        = '0;
                state_d      = LSU_BUSY;
            end else if (core_req_i) begin
                lsu_err_o = 1'b1;
            end
        end else if (mem_ready_i) begin
            core_rd_o = ext_rd;
            cnt_d     = '0;
            state_d   = LSU_IDLE;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == TO) begin
            lsu_err_o = 1'b1;
            cnt_d     = '0;
            state_d   = LSU_IDLE;
        end else begin
            core_stall_o = 1'b1;
            cnt_d        = cnt_q + CW'(1);
        end
    end
endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
- Load/store unit between the core datapath and data_mem.
- Converts core byte/halfword/word load-store requests into word-aligned memory accesses with byte enables and replicated write data.
- Sign/zero-extends returned read data.
- Stalls the core until the one-cycle-latency memory response arrives; flags misaligned/illegal accesses and response timeouts.

Parameters:
- TIMEOUT_CYCLES, 16, cycles spent in BUSY without mem_ready_i before the access is aborted with an error; 0 disables the timeout.

Ports:
- clk_i  in  1  system clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- core_req_i  in  1  core requests a memory access; held stable while core_stall_o=1
- core_we_i  in  1  1=store, 0=load
- core_size_i  in  3  access size (LDST_B/H/W/BU/HU)
- core_addr_i  in  32  byte address
- core_wd_i  in  32  store data, right-aligned
- core_rd_o  out  32  extended load data; valid only in the completion cycle
- core_stall_o  out  1  core must hold state and inputs
- lsu_err_o  out  1  one-cycle pulse: misaligned, illegal size, or timeout
- mem_req_o  out  1  memory request; single-cycle pulse per access
- mem_we_o  out  1  memory write enable
- mem_be_o  out  4  byte enables
- mem_addr_o  out  32  word address {core_addr_i[31:2],2'b00}
- mem_wd_o  out  32  lane-replicated write data
- mem_rd_i  in  32  memory read word, valid when mem_ready_i=1 in BUSY
- mem_ready_i  in  1  response valid; tie to 1 for data_mem

Behaviour:
- Reset: asynchronous, active-low (rst_ni=0). State is IDLE; latched size, offset and timeout counter are 0.
  - All outputs are 0 while core_req_i=0.
  - Reset mid-access aborts silently with no error pulse.
- States: IDLE, BUSY.
- IDLE, core_req_i=1 and access legal:
  - mem_req_o=1, mem_we_o=core_we_i, core_stall_o=1.
  - Latch size and addr[1:0].
  - Go to BUSY.
- IDLE, access illegal (H/HU with addr[0]=1, W with addr[1:0]!=0, or size in {3,6,7}):
  - lsu_err_o=1, mem_req_o=0, core_stall_o=0, core_rd_o=0.
  - Stay in IDLE.
- BUSY:
  - mem_req_o=0.
  - If mem_ready_i=1: core_stall_o=0, core_rd_o driven combinationally from mem_rd_i, go to IDLE.
  - Otherwise core_stall_o=1 and the counter increments.
  - If the counter reaches TIMEOUT_CYCLES (nonzero): lsu_err_o=1, core_stall_o=0, core_rd_o=0, go to IDLE.
- Latency with data_mem (ready=1): every load or store stalls exactly 1 cycle and completes in the 2nd cycle.
- Back-to-back requests: the completion cycle does not issue a new request; the next request is issued in the following IDLE cycle.
- Byte enables:
  - B/BU: 4'b0001<<addr[1:0].
  - H/HU: 4'b0011<<{addr[1],1'b0}.
  - W: 4'b1111.
  - Loads drive the same byte-enable value.
- Write data:
  - B: {4{wd[7:0]}}.
  - H: {2{wd[15:0]}}.
  - W: wd.
- Read extraction uses the latched offset:
  - B: sign-extend byte[off].
  - BU: zero-extend byte[off].
  - H: sign-extend half[off[1]].
  - HU: zero-extend half[off[1]].
  - W: word unchanged.
- core_req_i dropping while in BUSY is a protocol violation; the block ignores it and completes the access.
- mem_rd_i values such as fa11_1eaf or dead_beef are passed through and extended like any other data.

Decomposition:
- riscv_pkg constants: LDST_B=3'd0, LDST_H=3'd1, LDST_W=3'd2, LDST_BU=3'd4, LDST_HU=3'd5.
- riscv_pkg also holds the state enum lsu_state_t {LSU_IDLE, LSU_BUSY}.
- One combinational sub-module, lsu_rd_extend(size, offset, word -> rd), holds the load-extension mux.
- FSM, byte-enable generation and write-data generation stay in riscv_lsu.

Test Plan:
- SW addr 0x0000_0010, wd 0xCAFE_BABE, ready=1:
  - Cycle 0: req=1, we=1, be=4'b1111, wd=CAFEBABE, stall=1.
  - Cycle 1: stall=0.
- SB addr 0x13, wd 0x0000_00A5:
  - be=4'b1000, mem_wd=A5A5A5A5, addr=0x10.
- LB addr 0x11, mem_rd 0x1234_8076:
  - core_rd=0xFFFF_FF80 in cycle 1.
  - LBU with the same inputs gives 0x0000_0080.
- LH addr 0x12, mem_rd 0x9ABC_0000: core_rd=0xFFFF_9ABC.
- LHU addr 0x12, mem_rd 0x9ABC_0000: core_rd=0x0000_9ABC.
- LW addr 0x06 (misaligned): lsu_err_o=1, mem_req_o=0, stall=0 in the same cycle.
- LW addr 0x20 with mem_ready_i=0, TIMEOUT_CYCLES=4:
  - stall=1 for 5 cycles, then lsu_err_o=1, core_rd=0.
  - Deassert rst_ni in BUSY in a separate run: state returns to IDLE, stall=0 immediately.
